// File: rtl/id_ex_stage_if.sv
// Purpose : bundle of the ID/EX stage signals: ID fields, forwarding taps, EX outputs.
// Latency : n/a (wiring only).
// Backpressure: ex_hold freezes the stage; stall_id holds IF/ID on a load-use hazard.
// Ports   : master = upstream/test side (drives ID, EX/MEM, MEM/WB, flush, ex_hold);
//           slave  = the stage itself (drives stall_id, ex_*, stall_cnt).
interface id_ex_stage_if #(
  parameter int XLEN = 32,
  parameter int RW   = 5,
  parameter int CW   = 16
);
  // ID side
  logic            id_valid;
  logic [4:0]      id_alu_op;
  logic [RW-1:0]   id_rs1;
  logic [RW-1:0]   id_rs2;
  logic [RW-1:0]   id_rd;
  logic [XLEN-1:0] id_rs1_val;
  logic [XLEN-1:0] id_rs2_val;
  logic [XLEN-1:0] id_imm;
  logic            id_use_imm;
  logic            id_is_load;
  logic            id_is_store;
  logic            id_wb_en;
  // pipeline control
  logic            flush;
  logic            ex_hold;
  // EX/MEM forwarding tap
  logic            exm_valid;
  logic            exm_wb_en;
  logic            exm_is_load;
  logic [RW-1:0]   exm_rd;
  logic [XLEN-1:0] exm_res;
  // MEM/WB forwarding tap
  logic            mwb_valid;
  logic            mwb_wb_en;
  logic [RW-1:0]   mwb_rd;
  logic [XLEN-1:0] mwb_data;
  // stage outputs
  logic            stall_id;
  logic            ex_valid;
  logic            ex_wb_en;
  logic            ex_is_load;
  logic            ex_is_store;
  logic [RW-1:0]   ex_rd;
  logic [4:0]      ex_alu_op;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic [XLEN-1:0] ex_store_data;
  logic [CW-1:0]   stall_cnt;

  modport master (
    output id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_rs1_val, id_rs2_val,
           id_imm, id_use_imm, id_is_load, id_is_store, id_wb_en,
           flush, ex_hold,
           exm_valid, exm_wb_en, exm_is_load, exm_rd, exm_res,
           mwb_valid, mwb_wb_en, mwb_rd, mwb_data,
    input  stall_id, ex_valid, ex_wb_en, ex_is_load, ex_is_store, ex_rd,
           ex_alu_op, ex_op1, ex_op2, ex_store_data, stall_cnt
  );

  modport slave (
    input  id_valid, id_alu_op, id_rs1, id_rs2, id_rd, id_rs1_val, id_rs2_val,
           id_imm, id_use_imm, id_is_load, id_is_store, id_wb_en,
           flush, ex_hold,
           exm_valid, exm_wb_en, exm_is_load, exm_rd, exm_res,
           mwb_valid, mwb_wb_en, mwb_rd, mwb_data,
    output stall_id, ex_valid, ex_wb_en, ex_is_load, ex_is_store, ex_rd,
           ex_alu_op, ex_op1, ex_op2, ex_store_data, stall_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// Purpose : DLX ID/EX pipeline register with operand forwarding and load-use stall detection.
// Latency : one cycle ID -> ex_*; forwarding onto ex_op1/ex_op2/ex_store_data is combinational.
// Backpressure: ex_hold freezes all state; stall_id holds IF/ID and inserts one bubble per load-use.
// Ports   : clk, rst_n (async, active-low); bus (id_ex_stage_if.slave) carries ID fields,
//           flush/ex_hold, EX/MEM and MEM/WB forwarding taps, and all ex_* / stall outputs.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5,
  parameter int CW   = 16
) (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  logic            r_valid, r_use_imm, r_is_load, r_is_store, r_wb_en;
  logic [4:0]      r_alu_op;
  logic [RW-1:0]   r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0] r_rs1_val, r_rs2_val, r_imm;
  logic [CW-1:0]   r_stall_cnt;

  logic            rs2_used;
  logic            hazard;
  logic            stall;
  logic            exm_fwd_en, mwb_fwd_en;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // First match wins: the younger EX/MEM result shadows MEM/WB; r0 is hard zero.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RW-1:0]   src,
    input logic [XLEN-1:0] regval,
    input logic            e_en,
    input logic [RW-1:0]   e_rd,
    input logic [XLEN-1:0] e_res,
    input logic            m_en,
    input logic [RW-1:0]   m_rd,
    input logic [XLEN-1:0] m_data
  );
    logic [XLEN-1:0] v;
    if (src == '0)                 v = '0;
    else if (e_en && e_rd == src)  v = e_res;
    else if (m_en && m_rd == src)  v = m_data;
    else                           v = regval;
    return v;
  endfunction

  assign rs2_used = !bus.id_use_imm || bus.id_is_store;

  always_comb begin
    hazard = 1'b0;
    if (bus.id_valid && r_valid && r_is_load && r_rd != '0) begin
      if (r_rd == bus.id_rs1)              hazard = 1'b1;
      if (rs2_used && r_rd == bus.id_rs2)  hazard = 1'b1;
    end
  end

  // A flushed or frozen stage never asks ID to stall.
  assign stall = hazard && !bus.flush && !bus.ex_hold;

  assign exm_fwd_en = bus.exm_valid && bus.exm_wb_en && bus.exm_rd != '0;
  assign mwb_fwd_en = bus.mwb_valid && bus.mwb_wb_en && bus.mwb_rd != '0;

  assign fwd_rs1 = fwd_sel(r_rs1, r_rs1_val, exm_fwd_en, bus.exm_rd, bus.exm_res,
                           mwb_fwd_en, bus.mwb_rd, bus.mwb_data);
  assign fwd_rs2 = fwd_sel(r_rs2, r_rs2_val, exm_fwd_en, bus.exm_rd, bus.exm_res,
                           mwb_fwd_en, bus.mwb_rd, bus.mwb_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_alu_op    <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_is_load   <= 1'b0;
      r_is_store  <= 1'b0;
      r_wb_en     <= 1'b0;
      r_stall_cnt <= '0;
    end else if (bus.flush) begin
      // Datapath fields are left as-is; only control bits matter for a killed slot.
      r_valid    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
    end else if (bus.ex_hold) begin
      r_valid <= r_valid;
    end else if (stall) begin
      r_valid    <= 1'b0;
      r_wb_en    <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CW'(1);
    end else begin
      r_valid    <= bus.id_valid;
      r_alu_op   <= bus.id_alu_op;
      r_rs1      <= bus.id_rs1;
      r_rs2      <= bus.id_rs2;
      r_rd       <= bus.id_rd;
      r_rs1_val  <= bus.id_rs1_val;
      r_rs2_val  <= bus.id_rs2_val;
      r_imm      <= bus.id_imm;
      r_use_imm  <= bus.id_use_imm;
      r_is_load  <= bus.id_is_load;
      r_is_store <= bus.id_is_store;
      r_wb_en    <= bus.id_wb_en;
    end
  end

  assign bus.stall_id      = stall;
  assign bus.ex_valid      = r_valid;
  assign bus.ex_wb_en      = r_wb_en;
  assign bus.ex_is_load    = r_is_load;
  assign bus.ex_is_store   = r_is_store;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_alu_op     = r_alu_op;
  assign bus.ex_op1        = fwd_rs1;
  assign bus.ex_op2        = r_use_imm ? r_imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
// Purpose : scoreboard bench for id_ex_stage: forwarding, load-use stall, flush/hold, reset.
// Latency : expectations are queued when an ID instruction is driven and popped one edge later.
// Backpressure: ex_hold and stall_id scenarios are exercised directly.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int CW   = 4;  // narrow counter so saturation is reachable quickly

  logic clk;
  logic rst_n;

  id_ex_stage_if #(.XLEN(XLEN), .RW(RW), .CW(CW)) bus ();

  id_ex_stage #(.XLEN(XLEN), .RW(RW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    string       tag;
    bit          ctl_only;
    logic        vld, wb, ld, st;
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [31:0] op1, op2, sd;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic vld, input logic [4:0] op,
                      input logic [4:0] rd, input logic [31:0] op1, input logic [31:0] op2,
                      input logic [31:0] sd, input logic wb, input logic ld, input logic st);
    exp_t e;
    e.tag = tag; e.ctl_only = 1'b0;
    e.vld = vld; e.op = op; e.rd = rd; e.op1 = op1; e.op2 = op2; e.sd = sd;
    e.wb = wb; e.ld = ld; e.st = st;
    exp_q.push_back(e);
  endtask

  task automatic push_bubble(input string tag);
    exp_t e;
    e.tag = tag; e.ctl_only = 1'b1;
    e.vld = 1'b0; e.wb = 1'b0; e.ld = 1'b0; e.st = 1'b0;
    e.op = '0; e.rd = '0; e.op1 = '0; e.op2 = '0; e.sd = '0;
    exp_q.push_back(e);
  endtask

  // One rising edge; outputs are sampled 1ns later and checked against the queue head.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({e.tag, ".vld"}, 32'(bus.ex_valid),    32'(e.vld));
      chk({e.tag, ".wb"},  32'(bus.ex_wb_en),    32'(e.wb));
      chk({e.tag, ".ld"},  32'(bus.ex_is_load),  32'(e.ld));
      chk({e.tag, ".st"},  32'(bus.ex_is_store), 32'(e.st));
      if (!e.ctl_only) begin
        chk({e.tag, ".op"},  32'(bus.ex_alu_op), 32'(e.op));
        chk({e.tag, ".rd"},  32'(bus.ex_rd),     32'(e.rd));
        chk({e.tag, ".op1"}, bus.ex_op1,         e.op1);
        chk({e.tag, ".op2"}, bus.ex_op2,         e.op2);
        chk({e.tag, ".sd"},  bus.ex_store_data,  e.sd);
      end
    end
  endtask

  task automatic set_id(input logic vld, input logic [4:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] v1,
                        input logic [31:0] v2, input logic [31:0] imm, input logic use_imm,
                        input logic ld, input logic st, input logic wb);
    bus.id_valid = vld;  bus.id_alu_op = op;
    bus.id_rs1 = rs1;    bus.id_rs2 = rs2;    bus.id_rd = rd;
    bus.id_rs1_val = v1; bus.id_rs2_val = v2; bus.id_imm = imm;
    bus.id_use_imm = use_imm;
    bus.id_is_load = ld; bus.id_is_store = st; bus.id_wb_en = wb;
  endtask

  task automatic set_exm(input logic vld, input logic wb, input logic ld,
                         input logic [4:0] rd, input logic [31:0] res);
    bus.exm_valid = vld; bus.exm_wb_en = wb; bus.exm_is_load = ld;
    bus.exm_rd = rd;     bus.exm_res = res;
  endtask

  task automatic set_mwb(input logic vld, input logic wb, input logic [4:0] rd,
                         input logic [31:0] data);
    bus.mwb_valid = vld; bus.mwb_wb_en = wb; bus.mwb_rd = rd; bus.mwb_data = data;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_exm(0, 0, 0, 0, 0);
    set_mwb(0, 0, 0, 0);
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    // reset state
    chk("rst.vld",   32'(bus.ex_valid),  0);
    chk("rst.op1",   bus.ex_op1,         0);
    chk("rst.cnt",   32'(bus.stall_cnt), 0);
    chk("rst.stall", 32'(bus.stall_id),  0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ADD r1 = r2 + r3, then SUB r2 = r1 - r1 with r1 forwarded from EX/MEM
    set_id(1, 1, 2, 3, 1, 32'h5, 32'h6, 0, 0, 0, 0, 1);
    push("add", 1, 1, 1, 32'h5, 32'h6, 32'h6, 1, 0, 0);
    step();
    set_id(1, 2, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1);
    set_exm(1, 1, 0, 1, 32'h10);
    push("sub", 1, 2, 2, 32'h10, 32'h10, 32'h10, 1, 0, 0);
    step();

    // r5 written by both EX/MEM and MEM/WB: EX/MEM wins, then MEM/WB once EX/MEM drops wb_en
    set_id(1, 3, 5, 0, 6, 32'h1, 0, 32'h4, 1, 0, 0, 1);
    set_exm(1, 1, 0, 5, 32'hA);
    set_mwb(1, 1, 5, 32'hB);
    push("pri_exm", 1, 3, 6, 32'hA, 32'h4, 32'h0, 1, 0, 0);
    step();
    bus.ex_hold = 1'b1;
    bus.exm_wb_en = 1'b0;
    set_id(1, 9, 9, 9, 9, 32'h99, 32'h99, 32'h99, 0, 0, 0, 1);
    push("pri_mwb", 1, 3, 6, 32'hB, 32'h4, 32'h0, 1, 0, 0);
    step();

    // load-use: LW r3 <- [r7+8], then ADD r4 = r3 + 1
    bus.ex_hold = 1'b0;
    set_exm(0, 0, 0, 0, 0);
    set_mwb(0, 0, 0, 0);
    set_id(1, 1, 7, 0, 3, 32'h100, 0, 32'h8, 1, 1, 0, 1);
    push("lw", 1, 1, 3, 32'h100, 32'h8, 32'h0, 1, 1, 0);
    step();
    set_id(1, 1, 3, 0, 4, 0, 0, 32'h1, 1, 0, 0, 1);
    bus.ex_hold = 1'b1;
    #1;
    chk("lu.hold_stall", 32'(bus.stall_id), 0);
    push("lu.held", 1, 1, 3, 32'h100, 32'h8, 32'h0, 1, 1, 0);
    step();
    chk("lu.cnt0", 32'(bus.stall_cnt), 0);
    bus.ex_hold = 1'b0;
    #1;
    chk("lu.stall", 32'(bus.stall_id), 1);
    push_bubble("lu.bubble");
    step();
    chk("lu.cnt1", 32'(bus.stall_cnt), 1);
    // load now sits in EX/MEM; it must never be forwarded from there
    set_exm(1, 1, 1, 3, 32'hDEAD);
    #1;
    chk("lu.stall_end", 32'(bus.stall_id), 0);
    chk("lu.ldfwd", 32'(bus.ex_op1 === 32'hDEAD), 0);
    set_exm(0, 0, 0, 0, 0);
    set_mwb(1, 1, 3, 32'h77);
    push("lu.issue", 1, 1, 4, 32'h77, 32'h1, 32'h0, 1, 0, 0);
    step();
    chk("lu.cnt_keep", 32'(bus.stall_cnt), 1);

    // flush together with hold: flush wins
    set_mwb(0, 0, 0, 0);
    bus.flush = 1'b1;
    bus.ex_hold = 1'b1;
    set_id(1, 5, 1, 2, 7, 1, 2, 0, 0, 0, 0, 1);
    push_bubble("flush_hold");
    step();
    bus.flush = 1'b0;
    bus.ex_hold = 1'b0;
    set_id(1, 4, 8, 9, 10, 32'h123, 32'h456, 0, 0, 0, 0, 1);
    push("pre_hold", 1, 4, 10, 32'h123, 32'h456, 32'h456, 1, 0, 0);
    step();
    bus.ex_hold = 1'b1;
    set_id(1, 7, 1, 2, 11, 32'h999, 32'h888, 32'h777, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      push($sformatf("hold%0d", i), 1, 4, 10, 32'h123, 32'h456, 32'h456, 1, 0, 0);
      step();
    end
    chk("hold.cnt", 32'(bus.stall_cnt), 1);

    // r0 source with EX/MEM rd=0: never forwarded, reads zero
    bus.ex_hold = 1'b0;
    set_exm(1, 1, 0, 0, 32'hFFFF);
    set_id(1, 1, 0, 0, 12, 32'h55, 32'h66, 0, 0, 0, 0, 1);
    push("r0", 1, 1, 12, 32'h0, 32'h0, 32'h0, 1, 0, 0);
    step();

    // store: op2 = imm, store data = forwarded rs2
    set_exm(0, 0, 0, 0, 0);
    set_mwb(1, 1, 12, 32'hCAFE);
    set_id(1, 1, 11, 12, 0, 32'h1000, 32'h0, 32'h20, 1, 0, 1, 0);
    push("store", 1, 1, 0, 32'h1000, 32'h20, 32'hCAFE, 0, 0, 1);
    step();

    // asynchronous reset mid-cycle while ex_valid=1
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.vld", 32'(bus.ex_valid),      0);
    chk("arst.st",  32'(bus.ex_is_store),   0);
    chk("arst.op1", bus.ex_op1,             0);
    chk("arst.op2", bus.ex_op2,             0);
    chk("arst.sd",  bus.ex_store_data,      0);
    chk("arst.op",  32'(bus.ex_alu_op),     0);
    chk("arst.cnt", 32'(bus.stall_cnt),     0);
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // saturation: 15 stalls fill the 4-bit counter, 2 more must not wrap
    for (int i = 1; i <= 17; i++) begin
      set_id(1, 1, 7, 0, 3, 32'h100, 0, 32'h8, 1, 1, 0, 1);
      step();
      set_id(1, 1, 3, 0, 4, 0, 0, 32'h1, 1, 0, 0, 1);
      step();
      if (i == 15) chk("sat.15", 32'(bus.stall_cnt), 15);
    end
    chk("sat.17", 32'(bus.stall_cnt), 15);

    if (exp_q.size() != 0) chk("queue_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
